cordic_mag_arbiter: RTL and testbench

//  Shares one fully pipelined CORDIC magnitude unit (sqrt(x^2+y^2), Q15.16) among NUM_REQ requesters.

---
 rtl/cordic_mag_arbiter_if.sv | 35 +++
 rtl/cordic_mag_arbiter.sv | 132 +++++++++++++
 tb/tb_cordic_mag_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_mag_arbiter_if.sv
// Bundle between the CORDIC magnitude arbiter, its requesters, the shared
// CORDIC pipeline and the response consumer.
interface cordic_mag_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_x_i;
  logic [NUM_REQ*WIDTH-1:0] req_y_i;
  logic                     cordic_valid_o;
  logic [WIDTH-1:0]         cordic_x_o;
  logic [WIDTH-1:0]         cordic_y_o;
  logic                     cordic_valid_i;
  logic [WIDTH-1:0]         cordic_data_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic [ID_W-1:0]          resp_id_o;
  logic [WIDTH-1:0]         resp_data_o;
  logic                     busy_o;
  logic                     err_o;

  modport slave (
    input  req_valid_i, req_x_i, req_y_i, cordic_valid_i, cordic_data_i, resp_ready_i,
    output req_ready_o, cordic_valid_o, cordic_x_o, cordic_y_o,
           resp_valid_o, resp_id_o, resp_data_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_x_i, req_y_i, cordic_valid_i, cordic_data_i, resp_ready_i,
    input  req_ready_o, cordic_valid_o, cordic_x_o, cordic_y_o,
           resp_valid_o, resp_id_o, resp_data_o, busy_o, err_o
  );
endinterface

// File: rtl/cordic_mag_arbiter.sv
// Round-robin front end sharing one non-stallable CORDIC magnitude pipeline;
// credits bound outstanding work so the in-order result FIFO never overflows.
module cordic_mag_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cordic_mag_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cordic_valid;
  logic [WIDTH-1:0]   r_cordic_x;
  logic [WIDTH-1:0]   r_cordic_y;
  logic               r_err;

  logic [ID_W-1:0]    r_tag_mem [DEPTH];
  logic [PTR_W-1:0]   r_tag_wr;
  logic [PTR_W-1:0]   r_tag_rd;
  logic [CNT_W-1:0]   r_tag_cnt;

  logic [ID_W-1:0]    r_res_id   [DEPTH];
  logic [WIDTH-1:0]   r_res_data [DEPTH];
  logic [PTR_W-1:0]   r_res_wr;
  logic [PTR_W-1:0]   r_res_rd;
  logic [CNT_W-1:0]   r_res_cnt;

  logic [ID_W-1:0]    w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_issue;
  logic [NUM_REQ-1:0] w_ready;
  logic [WIDTH-1:0]   w_grant_x;
  logic [WIDTH-1:0]   w_grant_y;
  logic               w_tag_empty;
  logic               w_res_push;
  logic               w_resp_valid;
  logic               w_resp_pop;

  // Scan downward so the requester nearest the pointer is the last (winning) match.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_grant = r_rr_ptr;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (bus.req_valid_i[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_issue   = w_any && (r_cnt < CNT_W'(DEPTH));
  assign w_grant_x = bus.req_x_i[int'(w_grant)*WIDTH +: WIDTH];
  assign w_grant_y = bus.req_y_i[int'(w_grant)*WIDTH +: WIDTH];

  always_comb begin
    w_ready = '0;
    if (w_issue) w_ready[w_grant] = 1'b1;
  end

  assign w_tag_empty  = (r_tag_cnt == '0);
  assign w_res_push   = bus.cordic_valid_i && !w_tag_empty;
  assign w_resp_valid = (r_res_cnt != '0);
  assign w_resp_pop   = w_resp_valid && bus.resp_ready_i;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr       <= '0;
      r_cnt          <= '0;
      r_cordic_valid <= 1'b0;
      r_cordic_x     <= '0;
      r_cordic_y     <= '0;
      r_err          <= 1'b0;
      r_tag_wr       <= '0;
      r_tag_rd       <= '0;
      r_tag_cnt      <= '0;
      r_res_wr       <= '0;
      r_res_rd       <= '0;
      r_res_cnt      <= '0;
    end else begin
      r_cordic_valid <= w_issue;
      if (w_issue) begin
        r_cordic_x <= w_grant_x;
        r_cordic_y <= w_grant_y;
        r_rr_ptr   <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
        r_tag_wr   <= r_tag_wr + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(w_issue) - CNT_W'(w_resp_pop);

      // A result with no matching tag is stray: flag it and drop it.
      if (bus.cordic_valid_i && w_tag_empty) r_err <= 1'b1;
      if (w_res_push) begin
        r_tag_rd <= r_tag_rd + PTR_W'(1);
        r_res_wr <= r_res_wr + PTR_W'(1);
      end
      r_tag_cnt <= r_tag_cnt + CNT_W'(w_issue) - CNT_W'(w_res_push);

      if (w_resp_pop) r_res_rd <= r_res_rd + PTR_W'(1);
      r_res_cnt <= r_res_cnt + CNT_W'(w_res_push) - CNT_W'(w_resp_pop);
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers/counts make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (w_issue) r_tag_mem[r_tag_wr] <= w_grant;
    if (w_res_push) begin
      r_res_id[r_res_wr]   <= r_tag_mem[r_tag_rd];
      r_res_data[r_res_wr] <= bus.cordic_data_i;
    end
  end

  assign bus.req_ready_o    = w_ready;
  assign bus.cordic_valid_o = r_cordic_valid;
  assign bus.cordic_x_o     = r_cordic_x;
  assign bus.cordic_y_o     = r_cordic_y;
  assign bus.resp_valid_o   = w_resp_valid;
  assign bus.resp_id_o      = w_resp_valid ? r_res_id[r_res_rd]   : '0;
  assign bus.resp_data_o    = w_resp_valid ? r_res_data[r_res_rd] : '0;
  assign bus.busy_o         = (r_cnt != '0);
  assign bus.err_o          = r_err;

endmodule

// File: tb/tb_cordic_mag_arbiter.sv
// Directed bench for cordic_mag_arbiter with a fixed-latency CORDIC stand-in
// fed by the arbiter's issue port.
module tb_cordic_mag_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int LAT     = WIDTH / 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Requester k operands are Pythagorean triples; expected magnitudes in Q15.16.
  logic [31:0] exp_mag [4] = '{32'h000D_0000, 32'h0005_0000, 32'h0011_0000, 32'h0019_0000};

  cordic_mag_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  cordic_mag_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] mag(input logic signed [31:0] x, input logic signed [31:0] y);
    longint unsigned s;
    longint unsigned r;
    longint unsigned t;
    s = longint'(x) * longint'(x) + longint'(y) * longint'(y);
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= s) r = t;
    end
    return r[31:0];
  endfunction

  // CORDIC stand-in: LAT-stage pipeline, reset together with the arbiter.
  logic [LAT-1:0] pipe_v;
  logic [31:0]    pipe_d [LAT];

  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], bus.cordic_valid_o};
      pipe_d[0] <= mag(bus.cordic_x_o, bus.cordic_y_o);
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign bus.cordic_valid_i = pipe_v[LAT-1] | inject;
  assign bus.cordic_data_i  = pipe_d[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    inject           = 1'b0;
    bus.req_valid_i  = '0;
    bus.resp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    int issues;

    bus.req_x_i = {32'h0007_0000, 32'h0008_0000, 32'h0003_0000, 32'h0005_0000};
    bus.req_y_i = {32'h0018_0000, 32'h000F_0000, 32'h0004_0000, 32'h000C_0000};

    // Reset state
    do_reset();
    #1;
    check("rst_ready",   64'(bus.req_ready_o), 0);
    check("rst_cvalid",  64'(bus.cordic_valid_o), 0);
    check("rst_cx",      64'(bus.cordic_x_o), 0);
    check("rst_rvalid",  64'(bus.resp_valid_o), 0);
    check("rst_rdata",   64'(bus.resp_data_o), 0);
    check("rst_busy",    64'(bus.busy_o), 0);
    check("rst_err",     64'(bus.err_o), 0);

    // 1: single request from requester 1
    bus.req_valid_i  = 4'b0010;
    bus.resp_ready_i = 1'b1;
    #1 check("t1_ready", 64'(bus.req_ready_o), 64'b0010);
    @(negedge clk);
    bus.req_valid_i = '0;
    check("t1_cvalid", 64'(bus.cordic_valid_o), 1);
    check("t1_cx",     64'(bus.cordic_x_o), 64'h0003_0000);
    check("t1_cy",     64'(bus.cordic_y_o), 64'h0004_0000);
    check("t1_busy",   64'(bus.busy_o), 1);
    n = 1;
    while (!bus.resp_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", 64'(n), 19);
    check("t1_id",      64'(bus.resp_id_o), 1);
    check("t1_data",    64'(bus.resp_data_o), 64'h0005_0000);
    @(negedge clk);
    check("t1_drained", 64'(bus.resp_valid_o), 0);
    check("t1_idle",    64'(bus.busy_o), 0);

    // 2: all requesters valid, consumer always ready
    do_reset();
    bus.resp_ready_i = 1'b1;
    bus.req_valid_i  = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("t2_grant%0d", i), 64'(bus.req_ready_o), 64'(1) << (i % 4));
      @(negedge clk);
    end
    bus.req_valid_i = '0;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        check($sformatf("t2_id%0d", k),   64'(bus.resp_id_o), 64'(k % 4));
        check($sformatf("t2_data%0d", k), 64'(bus.resp_data_o), 64'(exp_mag[k % 4]));
        k++;
      end
    end
    check("t2_resp_count", 64'(k), 8);

    // 3: consumer stalled -> exactly DEPTH issues, then one pop frees one credit
    do_reset();
    bus.req_valid_i = 4'b1111;
    issues = 0;
    for (int c = 0; c < 12; c++) begin
      #1 if (bus.req_ready_o != '0) issues++;
      @(negedge clk);
    end
    check("t3_issues", 64'(issues), DEPTH);
    repeat (25) @(negedge clk);
    check("t3_rvalid",  64'(bus.resp_valid_o), 1);
    check("t3_head_id", 64'(bus.resp_id_o), 0);
    repeat (3) @(negedge clk);
    check("t3_hold_id",   64'(bus.resp_id_o), 0);
    check("t3_hold_data", 64'(bus.resp_data_o), 64'(exp_mag[0]));
    bus.resp_ready_i = 1'b1;
    #1 check("t3_no_bypass", 64'(bus.req_ready_o), 0);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    #1 check("t3_one_more", 64'(bus.req_ready_o), 64'b0001);
    check("t3_next_head", 64'(bus.resp_id_o), 1);
    @(negedge clk);
    #1 check("t3_full_again", 64'(bus.req_ready_o), 0);
    bus.req_valid_i = '0;

    // 4: cnt==7, issue and pop together keep cnt at 7
    do_reset();
    bus.req_valid_i = 4'b1111;
    repeat (7) @(negedge clk);
    bus.req_valid_i = '0;
    repeat (30) @(negedge clk);
    check("t4_rvalid", 64'(bus.resp_valid_o), 1);
    bus.req_valid_i  = 4'b1111;
    bus.resp_ready_i = 1'b1;
    #1 check("t4_swap_grant", 64'(bus.req_ready_o), 64'b1000);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    #1 check("t4_still_open", 64'(bus.req_ready_o), 64'b0001);
    @(negedge clk);
    #1 check("t4_now_full", 64'(bus.req_ready_o), 0);
    bus.req_valid_i = '0;

    // 5: stray CORDIC result with nothing outstanding
    do_reset();
    #1 check("t5_err_before", 64'(bus.err_o), 0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("t5_err_set",  64'(bus.err_o), 1);
    check("t5_no_resp",  64'(bus.resp_valid_o), 0);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 64'(bus.err_o), 1);
    check("t5_no_resp_later", 64'(bus.resp_valid_o), 0);

    // 6: reset with three ops in flight
    do_reset();
    bus.req_valid_i = 4'b1111;
    repeat (3) @(negedge clk);
    bus.req_valid_i = '0;
    repeat (4) @(negedge clk);
    check("t6_busy_before", 64'(bus.busy_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_cvalid", 64'(bus.cordic_valid_o), 0);
    check("t6_cx",     64'(bus.cordic_x_o), 0);
    check("t6_cy",     64'(bus.cordic_y_o), 0);
    check("t6_rvalid", 64'(bus.resp_valid_o), 0);
    check("t6_rid",    64'(bus.resp_id_o), 0);
    check("t6_busy",   64'(bus.busy_o), 0);
    check("t6_err",    64'(bus.err_o), 0);
    bus.req_valid_i = 4'b1111;
    #1 check("t6_rr_ptr", 64'(bus.req_ready_o), 64'b0001);
    bus.req_valid_i = '0;
    repeat (30) @(negedge clk);
    check("t6_no_late_resp", 64'(bus.resp_valid_o), 0);
    check("t6_no_late_err",  64'(bus.err_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
